xnor_popcount_pe: RTL and testbench
===================================

Name: xnor_popcount_pe

Overview:
- Parametrised successor to the single-bit XNOR convolution PE.
- Processes CH_WIDTH channel-packed binary activations per beat against a locally stored bank of TAPS weight words.
- Accumulates XNOR-popcount over one full kernel window and emits the sum plus a thresholded binary activation.
- Sits in the conv PE array; weights daisy-chain PE to PE, and activation/result streams use valid/ready handshakes.

Parameters:
- CH_WIDTH, 32, channels packed per beat (activation and weight word width).
- TAPS, 9, kernel taps per window (3x3 default); beats per output.
- ACC_WIDTH, $clog2(CH_WIDTH*TAPS+1), accumulator/sum width; must hold CH_WIDTH*TAPS.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- clear  in  1  synchronous frame flush; weights kept
- w_load  in  1  shift one weight word into bank
- w_in  in  CH_WIDTH  weight word from upstream PE
- w_out  out  CH_WIDTH  bank[TAPS-1], to downstream PE
- threshold  in  ACC_WIDTH  binarisation threshold, quasi-static
- act_valid  in  1  activation beat valid
- act_ready  out  1  PE accepts beat
- act_data  in  CH_WIDTH  activation word (bit=1 means +1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  ACC_WIDTH  popcount sum of window
- out_bit  out  1  out_sum >= threshold
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, async): state=IDLE, tap_cnt=0, acc=0, bank all 0, out_valid=0, out_sum=0, out_bit=0, act_ready=0 while asserted, busy=0.
- Weight bank: on w_load in IDLE, bank[0]<=w_in and bank[i]<=bank[i-1]. TAPS loads fill the bank; the first word loaded ends in bank[TAPS-1]. w_out is registered, so a chain of N PEs loads in N*TAPS cycles.
- w_load outside IDLE is ignored: bank unchanged.
- Tap k uses bank[TAPS-1-k], so weights are loaded in tap order 0..TAPS-1.
- Beat term: popcount(~(act_data ^ weight)), range 0..CH_WIDTH, zero-extended to ACC_WIDTH. No saturation is needed by construction.
- FSM states:
  - IDLE: act_ready = !w_load (load has priority). On an accepted beat: acc<=term, tap_cnt<=1, go ACCUM. If TAPS==1, go OUT directly.
  - ACCUM: act_ready=1. Each accepted beat: acc+=term, tap_cnt++. The beat with tap_cnt==TAPS-1 goes to OUT, out_sum<=acc+term, out_valid<=1. Cycles with act_valid low (bubbles) hold state.
  - OUT: out_valid=1; out_sum/out_bit stable until handshake. act_ready=out_ready (combinational).
    - out_ready&&act_valid: result retired, beat taken as tap 0 of next window (acc<=term, tap_cnt<=1, go ACCUM). Back-to-back windows have zero bubbles.
    - out_ready only: go IDLE, out_valid<=0.
- Latency: last beat accepted at edge t gives out_valid high after edge t; one-cycle latency.
- out_bit is registered together with out_sum, comparing against threshold sampled at that edge.
- clear (any state): next edge state=IDLE, acc=0, tap_cnt=0, out_valid=0. Bank is untouched. clear overrides a same-cycle beat, load, or output handshake (beat not consumed; act_ready=0 while clear is high).
- Reset mid-window: everything returns to reset values, including the bank; weights must be reloaded.

Decomposition:
- Shared package bnn_pe_pkg: state enum (IDLE, ACCUM, OUT), function clog2-based ACC_WIDTH helper.
- One sub-module: popcount_xnor (combinational, parameter CH_WIDTH, adder-tree popcount of XNOR), reusable by the FC layer.

Test Plan:
(bench: CH_WIDTH=8, TAPS=3, ACC_WIDTH=5)
- Load 8'hFF, 8'h00, 8'hF0; stream act FF, 00, F0 back-to-back, threshold=12 -> one cycle after third beat: out_valid=1, out_sum=24, out_bit=1.
- Same weights; acts 00, FF, 0F, threshold=12 -> out_sum=0, out_bit=0; out_ready held low 5 cycles -> out_sum/out_valid stable, act_ready=0.
- Two windows back-to-back with out_ready=1 and act_valid continuously high -> results 24 then 0 on consecutive windows, no idle cycle between windows, act_ready never drops.
- Bubbles: act_valid pattern 1,0,0,1,0,1 -> single result with out_sum=24, tap_cnt unchanged during bubbles.
- After first beat, assert clear for 1 cycle, then stream full window -> result reflects only post-clear beats (24); bank intact. w_load pulsed in ACCUM -> ignored, same sum.
- Assert rst low mid-window (async, between edges) -> out_valid, busy, out_sum drop to 0 immediately; bank reads 0 via w_out.

Source files
------------

// File: rtl/bnn_pe_pkg.sv
// Shared types and sizing helpers for the binary conv PE family.
// Used by the XNOR-popcount PE, its interface and the FC layer.
package bnn_pe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } pe_state_e;

  function automatic int acc_width(input int ch, input int taps);
    return $clog2(ch * taps + 1);
  endfunction

endpackage

// File: rtl/xnor_popcount_pe_if.sv
// Activation-in / result-out valid-ready streams of the XNOR PE.
// The master drives activations and accepts results.
interface xnor_popcount_pe_if
  import bnn_pe_pkg::*;
#(
  parameter int CH_WIDTH  = 32,
  parameter int ACC_WIDTH = acc_width(32, 9)
);

  logic                 act_valid;
  logic                 act_ready;
  logic [CH_WIDTH-1:0]  act_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_bit;

  modport master (
    output act_valid,
    output act_data,
    input  act_ready,
    input  out_valid,
    input  out_sum,
    input  out_bit,
    output out_ready
  );

  modport slave (
    input  act_valid,
    input  act_data,
    output act_ready,
    output out_valid,
    output out_sum,
    output out_bit,
    input  out_ready
  );

endinterface

// File: rtl/popcount_xnor.sv
// Combinational popcount of ~(act ^ weight) as a balanced adder tree.
// Inputs are zero-padded to a power of two; pad bits count as zero.
module popcount_xnor #(
  parameter int CH_WIDTH = 32,
  parameter int CNT_W    = $clog2(CH_WIDTH + 1)
) (
  input  logic [CH_WIDTH-1:0] act,
  input  logic [CH_WIDTH-1:0] weight,
  output logic [CNT_W-1:0]    count
);

  localparam int LV = $clog2(CH_WIDTH);
  localparam int P  = 1 << LV;

  logic [P-1:0] bits;

  assign bits = P'(~(act ^ weight));

  for (genvar l = 0; l <= LV; l++) begin : g_lv
    logic [CNT_W-1:0] s [P >> l];
    for (genvar i = 0; i < (P >> l); i++) begin : g_n
      if (l == 0) begin : g_leaf
        assign s[i] = CNT_W'(bits[i]);
      end else begin : g_add
        assign s[i] = g_lv[l-1].s[2*i] + g_lv[l-1].s[2*i+1];
      end
    end
  end

  assign count = g_lv[LV].s[0];

endmodule

// File: rtl/xnor_popcount_pe.sv
// Binary conv PE: XNOR-popcount over a TAPS-beat window with threshold.
// Weights daisy-chain through a shift bank; w_out feeds the next PE.
module xnor_popcount_pe
  import bnn_pe_pkg::*;
#(
  parameter int CH_WIDTH  = 32,
  parameter int TAPS      = 9,
  parameter int ACC_WIDTH = acc_width(CH_WIDTH, TAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 w_load,
  input  logic [CH_WIDTH-1:0]  w_in,
  output logic [CH_WIDTH-1:0]  w_out,
  input  logic [ACC_WIDTH-1:0] threshold,
  output logic                 busy,
  xnor_popcount_pe_if.slave    pe
);

  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW = $clog2(CH_WIDTH + 1);
  localparam logic [TW-1:0] LAST = TW'(TAPS - 1);
  localparam pe_state_e START = (TAPS == 1) ? OUT : ACCUM;

  pe_state_e            state, state_nx;
  logic [CH_WIDTH-1:0]  bank [TAPS];
  logic [TW-1:0]        tap_cnt;
  logic [ACC_WIDTH-1:0] acc, sum_nx;
  logic [PW-1:0]        pc;
  logic                 act_ready, accept, last;

  popcount_xnor #(
    .CH_WIDTH (CH_WIDTH),
    .CNT_W    (PW)
  ) u_pc (
    .act    (pe.act_data),
    .weight (bank[LAST - tap_cnt]),
    .count  (pc)
  );

  // acc and tap_cnt are zero outside ACCUM, so every beat is acc+term
  assign sum_nx       = acc + ACC_WIDTH'(pc);
  assign last         = (tap_cnt == LAST);
  assign accept       = pe.act_valid && act_ready;
  assign pe.act_ready = act_ready;
  assign busy         = (state != IDLE);
  assign w_out        = bank[TAPS-1];

  always_comb begin
    act_ready = 1'b0;
    unique case (state)
      IDLE:    act_ready = !w_load;
      ACCUM:   act_ready = 1'b1;
      OUT:     act_ready = pe.out_ready;
      default: act_ready = 1'b0;
    endcase
    if (clear || !rst) act_ready = 1'b0;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = START;
      ACCUM:   if (accept && last) state_nx = OUT;
      OUT:     if (pe.out_ready) state_nx = accept ? START : IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc          <= '0;
      tap_cnt      <= '0;
      pe.out_valid <= 1'b0;
      pe.out_sum   <= '0;
      pe.out_bit   <= 1'b0;
      for (int i = 0; i < TAPS; i++) bank[i] <= '0;
    end else if (clear) begin
      acc          <= '0;
      tap_cnt      <= '0;
      pe.out_valid <= 1'b0;
    end else begin
      if (w_load && state == IDLE) begin
        bank[0] <= w_in;
        for (int i = 1; i < TAPS; i++) bank[i] <= bank[i-1];
      end
      if (state == OUT && pe.out_ready) pe.out_valid <= 1'b0;
      if (accept) begin
        if (last) begin
          pe.out_sum   <= sum_nx;
          pe.out_bit   <= (sum_nx >= threshold);
          pe.out_valid <= 1'b1;
          acc          <= '0;
          tap_cnt      <= '0;
        end else begin
          acc     <= sum_nx;
          tap_cnt <= tap_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xnor_popcount_pe.sv
// Directed bench for xnor_popcount_pe with CH_WIDTH=8, TAPS=3.
// Weights FF,00,F0 loaded in tap order; vectors carry hand sums.
module tb_xnor_popcount_pe;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       w_load;
  logic [7:0] w_in;
  logic [7:0] w_out;
  logic [4:0] threshold;
  logic       busy;

  int total = 0;
  int bad   = 0;

  xnor_popcount_pe_if #(.CH_WIDTH(8), .ACC_WIDTH(5)) pif ();

  xnor_popcount_pe #(
    .CH_WIDTH  (8),
    .TAPS      (3),
    .ACC_WIDTH (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .w_load    (w_load),
    .w_in      (w_in),
    .w_out     (w_out),
    .threshold (threshold),
    .busy      (busy),
    .pe        (pif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [4:0] thr;
    logic [4:0] sum;
    logic       obit;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    int n;
    n = 0;
    pif.act_valid = 1'b1;
    pif.act_data  = d;
    #1;
    while (!pif.act_ready && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n == 20) begin
      total++;
      bad++;
      $display("FAIL beat_ready got=0 exp=1");
    end
    tick();
    pif.act_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hFF, 8'h00, 8'hF0, 5'd12, 5'd24, 1'b1};
    vecs[1] = '{8'h00, 8'hFF, 8'h0F, 5'd12, 5'd0,  1'b0};
    vecs[2] = '{8'hAA, 8'h55, 8'hFF, 5'd12, 5'd12, 1'b1};
    vecs[3] = '{8'hAA, 8'h55, 8'hFF, 5'd13, 5'd12, 1'b0};
    vecs[4] = '{8'h0F, 8'hF0, 8'hF0, 5'd20, 5'd16, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 5'd0,  5'd12, 1'b1};
    vecs[6] = '{8'hFF, 8'h00, 8'hF0, 5'd24, 5'd24, 1'b1};
    vecs[7] = '{8'h81, 8'h7E, 8'h3C, 5'd5,  5'd8,  1'b1};

    rst = 1'b0;
    clear = 1'b0;
    w_load = 1'b0;
    w_in = '0;
    threshold = '0;
    pif.act_valid = 1'b1;
    pif.act_data = '0;
    pif.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(pif.out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_sum", 32'(pif.out_sum), 0);
    chk("rst_act_ready", 32'(pif.act_ready), 0);
    chk("rst_w_out", 32'(w_out), 0);
    pif.act_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    w_load = 1'b1;
    w_in = 8'hFF;
    #1;
    chk("load_blocks_ready", 32'(pif.act_ready), 0);
    tick();
    w_in = 8'h00;
    tick();
    w_in = 8'hF0;
    tick();
    w_load = 1'b0;
    chk("w_out_first_word", 32'(w_out), 32'hFF);

    for (int v = 0; v < 8; v++) begin
      threshold = vecs[v].thr;
      pif.out_ready = 1'b1;
      beat(vecs[v].a0);
      beat(vecs[v].a1);
      beat(vecs[v].a2);
      chk($sformatf("vec%0d_valid", v), 32'(pif.out_valid), 1);
      chk($sformatf("vec%0d_sum", v), 32'(pif.out_sum), 32'(vecs[v].sum));
      chk($sformatf("vec%0d_bit", v), 32'(pif.out_bit), 32'(vecs[v].obit));
      tick();
      chk($sformatf("vec%0d_idle", v), 32'(busy), 0);
    end

    threshold = 5'd12;
    pif.out_ready = 1'b0;
    beat(8'h00);
    beat(8'hFF);
    beat(8'h0F);
    pif.act_valid = 1'b1;
    pif.act_data = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", 32'(pif.out_valid), 1);
      chk("stall_sum", 32'(pif.out_sum), 0);
      chk("stall_ready", 32'(pif.act_ready), 0);
      tick();
    end
    pif.act_valid = 1'b0;
    pif.out_ready = 1'b1;
    tick();
    chk("stall_retire", 32'(pif.out_valid), 0);

    begin
      logic [7:0] seq [6];
      seq = '{8'hFF, 8'h00, 8'hF0, 8'h00, 8'hFF, 8'h0F};
      pif.act_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
        pif.act_data = seq[i];
        #1;
        chk($sformatf("b2b_ready%0d", i), 32'(pif.act_ready), 1);
        tick();
        if (i == 2) begin
          chk("b2b_w0_valid", 32'(pif.out_valid), 1);
          chk("b2b_w0_sum", 32'(pif.out_sum), 24);
        end
        if (i == 5) begin
          chk("b2b_w1_valid", 32'(pif.out_valid), 1);
          chk("b2b_w1_sum", 32'(pif.out_sum), 0);
        end
      end
      pif.act_valid = 1'b0;
      tick();
    end

    begin
      logic       pat [6];
      logic [7:0] dat [6];
      logic [1:0] tap [6];
      logic       ov  [6];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      dat = '{8'hFF, 8'h55, 8'h55, 8'h00, 8'h55, 8'hF0};
      tap = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
      ov  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
        pif.act_valid = pat[i];
        pif.act_data = dat[i];
        tick();
        chk($sformatf("bub_tap%0d", i), 32'(dut.tap_cnt), 32'(tap[i]));
        chk($sformatf("bub_valid%0d", i), 32'(pif.out_valid), 32'(ov[i]));
      end
      chk("bub_sum", 32'(pif.out_sum), 24);
      pif.act_valid = 1'b0;
      tick();
    end

    beat(8'hFF);
    clear = 1'b1;
    pif.act_valid = 1'b1;
    pif.act_data = 8'h00;
    #1;
    chk("clear_ready", 32'(pif.act_ready), 0);
    tick();
    clear = 1'b0;
    pif.act_valid = 1'b0;
    chk("clear_busy", 32'(busy), 0);
    chk("clear_tap", 32'(dut.tap_cnt), 0);
    beat(8'hFF);
    w_load = 1'b1;
    w_in = 8'hAA;
    beat(8'h00);
    w_load = 1'b0;
    beat(8'hF0);
    chk("clear_valid", 32'(pif.out_valid), 1);
    chk("clear_sum", 32'(pif.out_sum), 24);
    chk("bank_kept", 32'(w_out), 32'hFF);
    tick();

    pif.out_ready = 1'b0;
    beat(8'hFF);
    beat(8'h00);
    beat(8'hF0);
    chk("pre_rst_valid", 32'(pif.out_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(pif.out_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_sum", 32'(pif.out_sum), 0);
    chk("arst_bit", 32'(pif.out_bit), 0);
    chk("arst_w_out", 32'(w_out), 0);
    chk("arst_ready", 32'(pif.act_ready), 0);
    tick();
    rst = 1'b1;
    pif.out_ready = 1'b1;
    tick();
    chk("post_rst_w_out", 32'(w_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
